// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game sequencer.
//   round_state_t : sequencer FSM states
//   MOLE_W        : width of the mole board pattern
//   SCORE_W       : width of the score counter
//   LFSR_TAPS     : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
`timescale 1ns/1ps
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_CLEAR,
    ST_DONE
  } round_state_t;

  localparam int MOLE_W  = 5;
  localparam int SCORE_W = 8;

  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the mole pattern source.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, loads SEED
//   state : current LFSR contents (advances every clock)
// A non-zero SEED never reaches the all-zero lock-up state.
`timescale 1ns/1ps
module lfsr8
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole game sequencer. Loads a pseudo-random mole pattern per
// round, times the round, ends it early once the board is empty, and
// counts rounds and hits. Owns every write to the mole board.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : single-cycle pulse that begins a game (IDLE or DONE)
//   board_state   : moles currently up on the board
//   score_trigger : hit level from the board; rising edges score
//   load, loadval : board write strobe and pattern (loadval=0 when idle)
//   score         : hits this game, saturating
//   round_num     : current round, 1-based, 0 in IDLE
//   busy          : high while a round is in progress
//   game_over     : high once the last round has cleared
`timescale 1ns/1ps
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned TICKS_PER_ROUND = 25_000_000,
  parameter int unsigned NUM_ROUNDS      = 10,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MOLE_W-1:0]  board_state,
  input  logic               score_trigger,
  output logic               load,
  output logic [MOLE_W-1:0]  loadval,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         round_num,
  output logic               busy,
  output logic               game_over
);

  localparam logic [31:0] LAST_TICK  = 32'(TICKS_PER_ROUND - 1);
  localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS);

  round_state_t state;
  logic [31:0]  timer;
  logic [7:0]   lfsr;
  logic         trig_p1;
  logic         score_edge;
  logic         lfsr_unused;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  // An all-zero pattern would show nothing, so substitute a single mole.
  function automatic logic [MOLE_W-1:0] pick_pattern(input logic [MOLE_W-1:0] bits);
    return (bits == '0) ? MOLE_W'(1) : bits;
  endfunction

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  // Only the low bits form the pattern; the upper bits just feed the shift.
  assign lfsr_unused = ^lfsr[7:MOLE_W];

  assign score_edge = score_trigger & ~trig_p1 &
                      ((state == ST_SHOW) | (state == ST_CLEAR));

  // Outputs are registered: each transition sets the values seen in the
  // state being entered. The pattern is taken from the LFSR value present
  // on the edge that enters LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      trig_p1   <= 1'b0;
      load      <= 1'b0;
      loadval   <= '0;
      score     <= '0;
      round_num <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      trig_p1 <= score_trigger;
      load    <= 1'b0;
      loadval <= '0;
      if (score_edge) score <= sat_inc(score);

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            load      <= 1'b1;
            loadval   <= pick_pattern(lfsr[MOLE_W-1:0]);
            score     <= '0;
            round_num <= 8'd1;
            busy      <= 1'b1;
            game_over <= 1'b0;
          end
        end
        ST_LOAD: begin
          state <= ST_SHOW;
          timer <= '0;
        end
        ST_SHOW: begin
          timer <= timer + 32'd1;
          // Timeout and all-clear in the same cycle collapse into one exit.
          if (timer == LAST_TICK || board_state == '0) begin
            state <= ST_CLEAR;
            load  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (round_num == LAST_ROUND) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state     <= ST_LOAD;
            round_num <= round_num + 8'd1;
            load      <= 1'b1;
            loadval   <= pick_pattern(lfsr[MOLE_W-1:0]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl. Two instances: a short-round
// game (4 ticks, 3 rounds) and a long-round one (1000 ticks, 2 rounds)
// used for early clear, saturation, ignored start and mid-game reset.
`timescale 1ns/1ps
module tb_mole_round_ctrl;

  localparam int unsigned TA   = 4;
  localparam int unsigned NA   = 3;
  localparam int unsigned TB   = 1000;
  localparam int unsigned NB   = 2;
  localparam int          LA   = TA + 2;
  localparam logic [7:0]  SEED = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       start_a = 1'b0;
  logic       trig_a  = 1'b0;
  logic [4:0] board_a = 5'b10101;
  logic       load_a, busy_a, over_a;
  logic [4:0] loadval_a;
  logic [7:0] score_a, round_a;

  logic       start_b   = 1'b0;
  logic       trig_b    = 1'b0;
  logic       clear_all = 1'b0;
  logic [4:0] board_reg_b;
  logic [4:0] board_b;
  logic       load_b, busy_b, over_b;
  logic [4:0] loadval_b;
  logic [7:0] score_b, round_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] lm, lm_prev;

  always #5 clk = ~clk;

  mole_round_ctrl #(.TICKS_PER_ROUND(TA), .NUM_ROUNDS(NA), .LFSR_SEED(SEED)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .board_state(board_a),
    .score_trigger(trig_a), .load(load_a), .loadval(loadval_a),
    .score(score_a), .round_num(round_a), .busy(busy_a), .game_over(over_a)
  );

  mole_round_ctrl #(.TICKS_PER_ROUND(TB), .NUM_ROUNDS(NB), .LFSR_SEED(SEED)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .board_state(board_b),
    .score_trigger(trig_b), .load(load_b), .loadval(loadval_b),
    .score(score_b), .round_num(round_b), .busy(busy_b), .game_over(over_b)
  );

  // Board behaviour: captures loadval on a load; the bench can wipe it
  // to emulate every mole being hit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      board_reg_b <= '0;
    else if (load_b) board_reg_b <= loadval_b;
  end
  assign board_b = clear_all ? 5'd0 : board_reg_b;

  // Reference LFSR from the polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [4:0] exp_pattern(input logic [7:0] s);
    return (s[4:0] == 5'd0) ? 5'd1 : s[4:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm      <= SEED;
      lm_prev <= SEED;
    end else begin
      lm_prev <= lm;
      lm      <= lfsr_next(lm);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One full game on dut_a, started from IDLE or DONE. Round schedule is
  // derived arithmetically: each round is LA cycles (LOAD, TA x SHOW, CLEAR).
  task automatic game_a(input bit randomize_inputs);
    int  exp_score;
    int  loads;
    int  phase;
    int  rnd;
    bit  in_game;
    bit  tv;
    bit  tprev;
    logic [4:0] exp_lv;
    exp_score = 0;
    loads     = 0;
    tv        = randomize_inputs ? bit'($urandom % 2) : 1'b0;
    tprev     = tv;
    trig_a    = tv;
    start_a   = 1'b1;
    for (int j = 1; j <= 3 * LA + 3; j++) begin
      @(negedge clk);
      phase   = (j - 1) % LA;
      rnd     = (j - 1) / LA + 1;
      in_game = (j <= 3 * LA);
      start_a = (randomize_inputs && j < 3 * LA) ? (($urandom % 6) == 0) : 1'b0;
      check("a_score", score_a, exp_score);
      if (in_game) begin
        exp_lv = (phase == 0) ? exp_pattern(lm_prev) : 5'd0;
        check("a_load", load_a, (phase == 0 || phase == LA - 1) ? 1 : 0);
        check("a_loadval", loadval_a, exp_lv);
        check("a_round", round_a, rnd);
        check("a_busy", busy_a, 1);
        check("a_over", over_a, 0);
      end else begin
        check("a_load_done", load_a, 0);
        check("a_loadval_done", loadval_a, 0);
        check("a_round_done", round_a, NA);
        check("a_busy_done", busy_a, 0);
        check("a_over_done", over_a, 1);
      end
      loads += int'(load_a);
      tv = randomize_inputs ? bit'($urandom % 2) : 1'b0;
      if (in_game && phase != 0 && tv && !tprev && exp_score < 255) exp_score++;
      tprev  = tv;
      trig_a = tv;
    end
    check("a_load_count", loads, 2 * NA);
    trig_a = 1'b0;
  endtask

  initial begin
    // Reset and idle.
    repeat (3) @(negedge clk);
    check("rst_a", {load_a, loadval_a, score_a, round_a, busy_a, over_a}, 0);
    check("rst_b", {load_b, loadval_b, score_b, round_b, busy_b, over_b}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_a", {load_a, loadval_a, score_a, round_a, busy_a, over_a}, 0);
      check("idle_b", {load_b, loadval_b, score_b, round_b, busy_b, over_b}, 0);
    end

    // Timeout games: quiet first, then randomized hits and stray starts,
    // each later game restarting from DONE.
    game_a(1'b0);
    game_a(1'b1);
    game_a(1'b1);

    // Early clear and scoring on dut_b.
    start_b = 1'b1;
    @(negedge clk);                                   // LOAD round 1
    start_b = 1'b0;
    check("b_load1", load_b, 1);
    check("b_lv1", loadval_b, exp_pattern(lm_prev));
    check("b_round1", round_b, 1);
    check("b_score0", score_b, 0);
    @(negedge clk);                                   // first SHOW
    check("b_show_load", load_b, 0);
    trig_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("b_score_level", score_b, 1);
    @(negedge clk);
    trig_b    = 1'b0;
    clear_all = 1'b1;
    check("b_show_still", load_b, 0);
    @(negedge clk);                                   // CLEAR
    clear_all = 1'b0;
    check("b_clear_load", load_b, 1);
    check("b_clear_lv", loadval_b, 0);
    check("b_clear_score", score_b, 1);
    check("b_clear_round", round_b, 1);
    @(negedge clk);                                   // LOAD round 2
    check("b_load2", load_b, 1);
    check("b_lv2", loadval_b, exp_pattern(lm_prev));
    check("b_round2", round_b, 2);

    // Saturation: 300 edges in round 2 SHOW.
    for (int e = 0; e < 300; e++) begin
      @(negedge clk);
      trig_b = 1'b1;
      @(negedge clk);
      trig_b = 1'b0;
    end
    @(negedge clk);
    check("b_sat_score", score_b, 255);
    check("b_sat_busy", busy_b, 1);
    check("b_sat_round", round_b, 2);
    check("b_sat_load", load_b, 0);

    // Start during SHOW is ignored.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_ign_load", load_b, 0);
    check("b_ign_round", round_b, 2);
    check("b_ign_score", score_b, 255);
    @(negedge clk);
    check("b_ign_load2", load_b, 0);

    // Mid-game reset, applied away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("b_async_rst", {load_b, loadval_b, score_b, round_b, busy_b, over_b}, 0);
    check("a_async_rst", {load_a, loadval_a, score_a, round_a, busy_a, over_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("b_post_rst", {load_b, loadval_b, score_b, round_b, busy_b, over_b}, 0);
    end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_rst_load", load_b, 1);
    check("b_rst_lv", loadval_b, exp_pattern(lm_prev));
    check("b_rst_round", round_b, 1);
    check("b_rst_busy", busy_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Game sequencer for the whack-a-mole board. It drives the mole board's `load` and `loadval` inputs with pseudo-random mole patterns, one per round. It times each round, ends a round early when every mole has been hit, and counts rounds and score from the board's `score_trigger` output. It sits between the top-level start button and the mole board register, and owns all writes to the board.

## Interface

Parameters:
- `TICKS_PER_ROUND`, default 25_000_000: clk cycles a pattern stays visible. Range 2..2^32-1.
- `NUM_ROUNDS`, default 10: rounds per game. Range 1..255.
- `LFSR_SEED`, default 8'hA5: LFSR reset value. Must be non-zero.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: active-high single-cycle pulse (already debounced) that begins a game.
- `board_state`  in  5: current active moles reported by the board.
- `score_trigger`  in  1: hit indication from the board, level (may stay high several cycles).
- `load`  out  1: one-cycle board load strobe.
- `loadval`  out  5: pattern written to the board when `load`=1. It is 0 whenever `load`=0.
- `score`  out  8: hits this game, saturating at 255.
- `round_num`  out  8: number of the current round, 1-based. It is 0 in IDLE.
- `busy`  out  1: high in LOAD, SHOW and CLEAR.
- `game_over`  out  1: high in DONE.

## Operation

- FSM states: IDLE, LOAD, SHOW, CLEAR, DONE.
- IDLE:
  - All outputs hold their reset values.
  - `start` → LOAD. On that transition: `score`←0 and `round_num`←1.
- LOAD (1 cycle):
  - `load`=1 and `loadval`=`lfsr[4:0]`. If `lfsr[4:0]`==0, `loadval`=5'b00001.
  - Timer ←0. Next state is SHOW.
- SHOW:
  - Timer increments every cycle.
  - Exit to CLEAR when timer==`TICKS_PER_ROUND`-1, or when `board_state`==0 (all moles hit). Whichever happens first ends the round.
- CLEAR (1 cycle):
  - `load`=1 and `loadval`=0, which wipes any remaining moles.
  - If `round_num`==`NUM_ROUNDS`, go to DONE.
  - Otherwise `round_num`+1 and go to LOAD.
- DONE:
  - `game_over`=1. `score` and `round_num` hold their values.
  - `start` → LOAD, with `score`←0 and `round_num`←1.
- `start` in LOAD, SHOW or CLEAR is ignored.
- Scoring:
  - Rising edges of `score_trigger` are detected against a registered copy.
  - Each edge seen in SHOW or CLEAR adds 1 to `score`. Edges in any other state are dropped.
  - `score` saturates at 255 and never wraps.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), maximal length 255.
  - Advances every clk cycle in every state, so the pattern depends on when the player presses `start`.
  - Never reaches 0.

## Timing

- Reset values:
  - State IDLE; `load`=0, `loadval`=0, `score`=0, `round_num`=0, `busy`=0, `game_over`=0.
  - LFSR=`LFSR_SEED`; edge-detect register=0.
- All outputs are registered.
- `start` sampled at edge N → `load`=1 during cycle N+1 (LOAD).
- The board captures `loadval` at the end of LOAD, so `board_state` is valid from the first SHOW cycle.
- Without early clear, a round lasts exactly 1 (LOAD) + `TICKS_PER_ROUND` (SHOW) + 1 (CLEAR) cycles.
- Early clear: `board_state`==0 seen in SHOW cycle k → CLEAR in cycle k+1.
- Timeout and all-clear in the same cycle: one transition to CLEAR, counted once.
- A score edge in the same cycle as the SHOW→CLEAR transition is still counted.
- A score edge in the same cycle as the CLEAR→DONE transition is still counted.
- Reset asserted mid-game returns everything to reset values immediately (asynchronous). No CLEAR load is issued; the board is reset by the same `rst_n`.

## Structure

- Shared package `mole_pkg` holds:
  - the state enum `round_state_t`;
  - `MOLE_W`=5 and `SCORE_W`=8;
  - `LFSR_TAPS`=8'b1011_1000.
- One sub-module, `lfsr8`:
  - ports: clk, rst_n, seed parameter;
  - output: 8-bit state; free-running.
- Timer is a 32-bit counter.
- FSM, score counter and edge detect all live in `mole_round_ctrl`.

## Test plan

- Reset then idle:
  - Stimulus: hold `rst_n` low, release, run 100 cycles with no `start`.
  - Required: `load` never asserts and all outputs stay 0.
- Full timeout game:
  - Stimulus: `TICKS_PER_ROUND`=4, `NUM_ROUNDS`=3, `board_state` held non-zero, pulse `start`.
  - Required: exactly 6 `load` pulses, alternating non-zero and 0; `game_over` rises 18 cycles after `start`; `score`=0.
- Early clear and scoring:
  - Stimulus: model the board; in round 1 raise `score_trigger` for 3 cycles, then drive `board_state`=0.
  - Required: `score`=1 and CLEAR on the next cycle.
- Saturation:
  - Stimulus: 300 `score_trigger` edges in SHOW, with `TICKS_PER_ROUND` large.
  - Required: `score`=255.
- `start` handling:
  - Stimulus: `start` during SHOW, then `start` in DONE.
  - Required: the first is ignored; the second gives `score`=0, `round_num`=1 and `load` on the next cycle.
- Mid-game reset:
  - Stimulus: assert `rst_n` low in SHOW of round 2.
  - Required: outputs drop to 0 with no clock edge needed; state returns to IDLE.
